// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, next-PC source select, flow-control FSM states.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        PC_NEXT = 2'd0,
        PC_BR   = 2'd1,
        PC_JR   = 2'd2,
        PC_J    = 2'd3
    } pcsrc_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } flow_state_t;

    // Instruction addresses are always word aligned.
    function automatic word_t align_word(input word_t addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/hazard_if.sv
// Hazard-unit control bundle; the hazard unit drives it, the flow controller consumes it.
interface hazard_if;
    logic pc_EN;
    logic ifid_EN;
    logic idex_flush;

    modport hu   (output pc_EN, output ifid_EN, output idex_flush);
    modport fcif (input  pc_EN, input  ifid_EN, input  idex_flush);
endinterface

// File: rtl/pc_reg.sv
// Program counter register with next-PC selection and word alignment on every load.
module pc_reg
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  sel,
    input  logic [31:0] branch_target,
    input  logic [31:0] jr_target,
    input  logic [31:0] j_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    word_t pc_next;

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        pc_next = pc_plus4;
        unique case (pcsrc_t'(sel))
            PC_NEXT: pc_next = pc_plus4;
            PC_BR:   pc_next = branch_target;
            PC_JR:   pc_next = jr_target;
            PC_J:    pc_next = j_target;
            default: pc_next = pc_plus4;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= align_word(PC_INIT);
        end else if (en) begin
            pc <= align_word(pc_next);
        end
    end

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Pipeline flow controller: turns hazard, cache and redirect status into per-stage
// latch enables/bubbles, owns the PC, the memory-wait freeze, sticky halt and stall counter.
module pipe_flow_ctrl
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmem_req,
    input  logic             halt_in,
    input  logic             pc_EN,
    input  logic             ifid_EN,
    input  logic             idex_flush,
    input  logic [1:0]       pcsrc,
    input  logic [31:0]      branch_target,
    input  logic [31:0]      jr_target,
    input  logic [31:0]      j_target,
    output logic [31:0]      imemaddr,
    output logic [31:0]      pc_plus4,
    output logic             ifid_we,
    output logic             ifid_bubble,
    output logic             idex_we,
    output logic             idex_bubble,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             halt_out,
    output logic [CNT_W-1:0] stall_cnt
);

    hazard_if hif ();

    assign hif.pc_EN      = pc_EN;
    assign hif.ifid_EN    = ifid_EN;
    assign hif.idex_flush = idex_flush;

    flow_state_t state;
    logic        freeze;
    logic        mem_stall;
    logic        advance;
    logic        redirect;
    logic        pc_upd;

    assign freeze    = dmem_req & ~dhit;
    // DWAIT keeps the pipe frozen until dhit even if the request line drops.
    assign mem_stall = freeze | ((state == DWAIT) & ~dhit);
    assign advance   = ~RST & (state != HALTED) & ~mem_stall;
    assign redirect  = (pcsrc_t'(pcsrc) != PC_NEXT);
    assign pc_upd    = advance & ((hif.pc_EN & ihit) | redirect);

    assign exmem_we    = advance;
    assign memwb_we    = advance;
    assign idex_we     = advance;
    assign idex_bubble = advance & hif.idex_flush;
    assign ifid_we     = advance & (hif.ifid_EN | redirect);
    assign ifid_bubble = advance & (redirect | ~ihit);

    pc_reg #(
        .PC_INIT (PC_INIT)
    ) u_pc_reg (
        .clk           (CLK),
        .rst           (RST),
        .en            (pc_upd),
        .sel           (pcsrc),
        .branch_target (branch_target),
        .jr_target     (jr_target),
        .j_target      (j_target),
        .pc            (imemaddr),
        .pc_plus4      (pc_plus4)
    );

    // Freeze/halt FSM, sticky halt flag and saturating stall counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= RUN;
            halt_out  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (advance && halt_in) begin
                state    <= HALTED;
                halt_out <= 1'b1;
            end else if (state != HALTED) begin
                state <= mem_stall ? DWAIT : RUN;
            end
            if ((state != HALTED) && !pc_upd && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Directed self-checking bench for pipe_flow_ctrl: core 0 defaults plus a core 1
// instance (PC_INIT=0x200, 4-bit stall counter) driven by the same stimulus.
module tb_pipe_flow_ctrl;

    logic        CLK;
    logic        RST;
    logic        ihit, dhit, dmem_req, halt_in;
    logic        pc_EN, ifid_EN, idex_flush;
    logic [1:0]  pcsrc;
    logic [31:0] branch_target, jr_target, j_target;

    logic [31:0] imemaddr0, pc_plus40, imemaddr1, pc_plus41;
    logic        ifid_we0, ifid_bubble0, idex_we0, idex_bubble0, exmem_we0, memwb_we0, halt_out0;
    logic        ifid_we1, ifid_bubble1, idex_we1, idex_bubble1, exmem_we1, memwb_we1, halt_out1;
    logic [15:0] stall_cnt0;
    logic [3:0]  stall_cnt1;
    logic [5:0]  ctl0, ctl1;

    int checks   = 0;
    int failures = 0;

    assign ctl0 = {ifid_we0, ifid_bubble0, idex_we0, idex_bubble0, exmem_we0, memwb_we0};
    assign ctl1 = {ifid_we1, ifid_bubble1, idex_we1, idex_bubble1, exmem_we1, memwb_we1};

    pipe_flow_ctrl u_core0 (
        .CLK (CLK), .RST (RST), .ihit (ihit), .dhit (dhit), .dmem_req (dmem_req),
        .halt_in (halt_in), .pc_EN (pc_EN), .ifid_EN (ifid_EN), .idex_flush (idex_flush),
        .pcsrc (pcsrc), .branch_target (branch_target), .jr_target (jr_target),
        .j_target (j_target), .imemaddr (imemaddr0), .pc_plus4 (pc_plus40),
        .ifid_we (ifid_we0), .ifid_bubble (ifid_bubble0), .idex_we (idex_we0),
        .idex_bubble (idex_bubble0), .exmem_we (exmem_we0), .memwb_we (memwb_we0),
        .halt_out (halt_out0), .stall_cnt (stall_cnt0)
    );

    pipe_flow_ctrl #(.PC_INIT (32'h0000_0200), .CNT_W (4)) u_core1 (
        .CLK (CLK), .RST (RST), .ihit (ihit), .dhit (dhit), .dmem_req (dmem_req),
        .halt_in (halt_in), .pc_EN (pc_EN), .ifid_EN (ifid_EN), .idex_flush (idex_flush),
        .pcsrc (pcsrc), .branch_target (branch_target), .jr_target (jr_target),
        .j_target (j_target), .imemaddr (imemaddr1), .pc_plus4 (pc_plus41),
        .ifid_we (ifid_we1), .ifid_bubble (ifid_bubble1), .idex_we (idex_we1),
        .idex_bubble (idex_bubble1), .exmem_we (exmem_we1), .memwb_we (memwb_we1),
        .halt_out (halt_out1), .stall_cnt (stall_cnt1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 2 time units after the rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #2;
        end
    endtask

    initial begin
        RST = 1'b1; ihit = 1'b1; dhit = 1'b0; dmem_req = 1'b0; halt_in = 1'b0;
        pc_EN = 1'b1; ifid_EN = 1'b1; idex_flush = 1'b0; pcsrc = 2'd0;
        branch_target = 32'h0; jr_target = 32'h0; j_target = 32'h0;

        #3;
        chk("rst_pc0", imemaddr0, 32'h0);
        chk("rst_pc1", imemaddr1, 32'h200);
        chk("rst_ctl0", 32'(ctl0), 32'h0);
        chk("rst_cnt0", 32'(stall_cnt0), 32'h0);
        chk("rst_halt0", 32'(halt_out0), 32'h0);

        @(negedge CLK); @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("run_ctl0", 32'(ctl0), 32'b101011);
        chk("run_ctl1", 32'(ctl1), 32'b101011);
        tick(1);
        chk("step_pc4", imemaddr0, 32'h4);
        chk("step_plus4", pc_plus40, 32'h8);
        chk("step_pc1", imemaddr1, 32'h204);
        tick(1);
        chk("step_pc8", imemaddr0, 32'h8);
        tick(2);
        chk("step_pc10", imemaddr0, 32'h10);

        // load-use stall at 0x10
        pc_EN = 1'b0; ifid_EN = 1'b0; idex_flush = 1'b1;
        #1;
        chk("lu_ctl", 32'(ctl0), 32'b001111);
        tick(1);
        chk("lu_pc", imemaddr0, 32'h10);
        chk("lu_cnt", 32'(stall_cnt0), 32'd1);
        pc_EN = 1'b1; ifid_EN = 1'b1; idex_flush = 1'b0;
        tick(4);
        chk("pre_br_pc", imemaddr0, 32'h20);

        // taken branch together with an ID/EX flush
        pcsrc = 2'd1; branch_target = 32'h40; idex_flush = 1'b1;
        #1;
        chk("br_ctl", 32'(ctl0), 32'b111111);
        tick(1);
        chk("br_pc0", imemaddr0, 32'h40);
        chk("br_pc1", imemaddr1, 32'h40);
        chk("br_cnt", 32'(stall_cnt0), 32'd1);

        // JR redirect beats pc_EN=0 and ihit=0; target gets aligned
        pcsrc = 2'd2; jr_target = 32'h83; idex_flush = 1'b0; pc_EN = 1'b0; ihit = 1'b0;
        #1;
        chk("jr_ctl", 32'(ctl0), 32'b111011);
        tick(1);
        chk("jr_pc", imemaddr0, 32'h80);
        chk("jr_cnt", 32'(stall_cnt0), 32'd1);

        // icache miss without redirect
        pcsrc = 2'd0; pc_EN = 1'b1;
        #1;
        chk("imiss_ctl", 32'(ctl0), 32'b111011);
        tick(1);
        chk("imiss_pc", imemaddr0, 32'h80);
        chk("imiss_cnt", 32'(stall_cnt0), 32'd2);
        ihit = 1'b1;

        // dcache miss for 5 cycles with a pending jump held on the inputs
        dmem_req = 1'b1; dhit = 1'b0; pcsrc = 2'd3; j_target = 32'h100;
        #1;
        chk("dmiss_ctl", 32'(ctl0), 32'b000000);
        tick(5);
        chk("dmiss_ctl_end", 32'(ctl0), 32'b000000);
        chk("dmiss_pc", imemaddr0, 32'h80);
        chk("dmiss_cnt", 32'(stall_cnt0), 32'd7);
        dhit = 1'b1;
        #1;
        chk("dhit_ctl", 32'(ctl0), 32'b111011);
        tick(1);
        chk("dhit_pc", imemaddr0, 32'h100);
        chk("dhit_cnt", 32'(stall_cnt0), 32'd7);
        dmem_req = 1'b0; dhit = 1'b0;

        // J to top of address space, then PC+4 wraps
        j_target = 32'hFFFF_FFFC;
        tick(1);
        chk("wrap_pc", imemaddr0, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus40, 32'h0);
        pcsrc = 2'd0;
        tick(1);
        chk("wrap_pc0", imemaddr0, 32'h0);

        // 20-cycle stall: 16-bit counter keeps counting, 4-bit one saturates
        pc_EN = 1'b0;
        tick(20);
        chk("sat_cnt0", 32'(stall_cnt0), 32'd27);
        chk("sat_cnt1", 32'(stall_cnt1), 32'd15);
        chk("sat_pc", imemaddr0, 32'h0);
        pc_EN = 1'b1;
        tick(1);
        chk("post_sat_pc", imemaddr0, 32'h4);

        // halt while advancing
        halt_in = 1'b1;
        tick(1);
        halt_in = 1'b0; pcsrc = 2'd1; branch_target = 32'h40;
        #1;
        chk("halt_out0", 32'(halt_out0), 32'h1);
        chk("halt_out1", 32'(halt_out1), 32'h1);
        chk("halt_pc", imemaddr0, 32'h8);
        chk("halt_ctl", 32'(ctl0), 32'b000000);
        tick(10);
        chk("halted_pc", imemaddr0, 32'h8);
        chk("halted_cnt", 32'(stall_cnt0), 32'd27);
        chk("halted_hold", 32'(halt_out0), 32'h1);

        // async reset from HALTED, mid-cycle
        pcsrc = 2'd0;
        @(negedge CLK); #1;
        RST = 1'b1;
        #1;
        chk("arst_halt0", 32'(halt_out0), 32'h0);
        chk("arst_pc0", imemaddr0, 32'h0);
        chk("arst_pc1", imemaddr1, 32'h200);
        chk("arst_cnt1", 32'(stall_cnt1), 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        tick(2);
        chk("rerun_pc", imemaddr0, 32'h8);

        // async reset while running clears enables before the next edge
        @(negedge CLK); #1;
        chk("prerst_ctl", 32'(ctl0), 32'b101011);
        RST = 1'b1;
        #1;
        chk("arst_run_ctl", 32'(ctl0), 32'b000000);
        chk("arst_run_pc", imemaddr0, 32'h0);
        @(negedge CLK);
        RST = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_flow_ctrl.md
Name: pipe_flow_ctrl

Overview:
Consumer end of the hazard-unit interface. Takes pc_EN, ifid_EN and idex_flush from the hazard unit, plus cache hit and redirect information, and turns them into the per-stage latch enables and bubble controls for the 5-stage pipeline. Owns the PC register, next-PC selection, the memory-wait freeze FSM, the sticky halt and a stall counter. Sits between the hazard unit, the caches and the pipeline latches in each core.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset (core 1 instance uses 32'h0000_0200)
CNT_W, 16, width of stall counter

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-high reset
ihit  input  1  icache hit: instruction for imemaddr is valid this cycle
dhit  input  1  dcache hit: outstanding MEM-stage access completes this cycle
dmem_req  input  1  MEM stage holds a load or store (dmemREN|dmemWEN)
halt_in  input  1  HALT instruction present in MEM/WB
pc_EN  input  1  from hazard unit: allow PC update
ifid_EN  input  1  from hazard unit: allow IF/ID update
idex_flush  input  1  from hazard unit: insert bubble into ID/EX
pcsrc  input  2  0 = PC+4, 1 = branch target, 2 = JR target, 3 = J target
branch_target  input  32  resolved branch address
jr_target  input  32  register jump address
j_target  input  32  jump address
imemaddr  output  32  current PC
pc_plus4  output  32  imemaddr + 4, passed into IF/ID
ifid_we  output  1  IF/ID latch enable
ifid_bubble  output  1  IF/ID loads a NOP (valid=0)
idex_we  output  1  ID/EX latch enable
idex_bubble  output  1  ID/EX loads a NOP
exmem_we  output  1  EX/MEM latch enable
memwb_we  output  1  MEM/WB latch enable
halt_out  output  1  core halted (sticky)
stall_cnt  output  CNT_W  cycles in which the PC did not advance, saturating

Behaviour:
- FSM states: RUN, DWAIT, HALTED. Reset enters RUN with the values below.
- Reset (async, immediate): PC = PC_INIT; halt_out = 0; stall_cnt = 0; all *_we = 0 and all *_bubble = 0 while RST is high.
- freeze = dmem_req & ~dhit.
- RUN to DWAIT when freeze. DWAIT to RUN on the cycle dhit = 1. In that cycle the pipe advances normally.
- In DWAIT, or whenever freeze = 1: all *_we = 0, all *_bubble = 0, and the PC holds. Freeze has top priority after reset and HALTED.
- advance = (state != HALTED) & ~freeze.
- exmem_we = memwb_we = advance.
- idex_we = advance. idex_bubble = advance & idex_flush.
- ifid_we = advance & (ifid_EN | redirect), where redirect = (pcsrc != 0).
- ifid_bubble = advance & (redirect | ~ihit). This squashes the wrong-path fetch or inserts a bubble while the instruction fetch is pending.
- PC update at the clock edge when advance & ((pc_EN & ihit) | redirect). The next value is selected by pcsrc. Redirect wins over stall and over ~ihit.
- PC arithmetic is 32-bit, and PC+4 wraps modulo 2^32. PC bits [1:0] are forced to 0 on load.
- Latency: a redirect presented in cycle N appears on imemaddr in cycle N+1.
- Halt: advance & halt_in sets halt_out and enters HALTED at that edge. HALTED is exited only by RST.
- In HALTED: all *_we = 0, all *_bubble = 0, the PC is frozen and stall_cnt is frozen.
- stall_cnt: increments in any non-HALTED cycle where the PC does not update. It saturates at all-ones.
- Simultaneous events:
  - freeze together with redirect: the redirect is held (not lost) because the inputs persist while the latches are frozen.
  - idex_flush together with redirect: both bubbles are applied.
- RST mid-DWAIT: returns to RUN immediately. Any outstanding cache request is the cache's responsibility.

Decomposition:
- cpu_types_pkg: word_t, a pcsrc_t enum (PC_NEXT, PC_BR, PC_JR, PC_J) and a flow_state_t enum (RUN, DWAIT, HALTED).
- Add a modport "fcif" to the hazard interface. It takes pc_EN, ifid_EN and idex_flush as inputs.
- One natural sub-module: pc_reg. It holds the PC register, next-PC mux and alignment, with inputs en and sel.

Test Plan:
- Reset release with ihit = 1, pcsrc = 0, no hazards: imemaddr steps 0x0, 0x4, 0x8. All *_we = 1 and all bubbles = 0 from cycle 1.
- Load-use: hazard drives pc_EN = 0, ifid_EN = 0, idex_flush = 1 for 1 cycle at PC 0x10. Required: PC holds 0x10, ifid_we = 0, idex_bubble = 1, stall_cnt increments by 1.
- Branch taken: pcsrc = 1, branch_target = 0x40 at PC 0x20. Required: next imemaddr = 0x40, and ifid_bubble = 1 in the redirect cycle.
- Dcache miss: dmem_req = 1, dhit = 0 for 5 cycles, then 1. Required: all *_we = 0 for 5 cycles, the PC is frozen, stall_cnt += 5. Normal advance resumes on the dhit cycle.
- Halt: halt_in = 1 while advancing. Required: halt_out = 1 from the next cycle, the PC stays frozen through 10 further cycles, and RST clears halt_out and reloads PC_INIT (0x200 for core 1).
- Counter saturation and async reset: with CNT_W = 4, a stall of 20 cycles must hold stall_cnt at 15. Asserting RST mid-cycle must clear the outputs before the next clock edge.
